// File: rtl/player_state_pkg.sv
// -----------------------------------------------------------------------------
// player_state_pkg
// Shared definitions for the per-player game-state controller:
//   - player_state_t : 3-bit FSM state encoding
//   - COMBO_*        : comboMove codes
//   - SCREEN_X_MAX   : rightmost legal horizontal position
//   - walk_step_x()  : one saturating horizontal step
// -----------------------------------------------------------------------------
package player_state_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CROUCH = 3'd1,
    ST_JUMP   = 3'd2,
    ST_ATTACK = 3'd3,
    ST_STUN   = 3'd4
  } player_state_t;

  localparam logic [1:0] COMBO_NONE    = 2'd0;
  localparam logic [1:0] COMBO_NORMAL  = 2'd1;
  localparam logic [1:0] COMBO_SPECIAL = 2'd2;
  localparam logic [1:0] COMBO_SUPER   = 2'd3;

  localparam int SCREEN_X_MAX = 86;

  // One walk step, clamped to [x_min, x_max]; done in int so it cannot wrap.
  function automatic logic [6:0] walk_step_x(input logic [6:0] x,
                                             input logic       go_right,
                                             input int         step,
                                             input int         x_min,
                                             input int         x_max);
    int nx;
    nx = go_right ? (int'(x) + step) : (int'(x) - step);
    if (nx < x_min) nx = x_min;
    if (nx > x_max) nx = x_max;
    return 7'(nx);
  endfunction

endpackage

// File: rtl/tick_countdown.sv
// -----------------------------------------------------------------------------
// tick_countdown
// Loadable down-counter advanced only by the game tick. Saturates at zero.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (count -> 0)
//   tick        : advance enable
//   load        : on a tick, load load_value instead of counting down
//   load_value  : value to load
//   count       : current count
//   zero        : count == 0
// -----------------------------------------------------------------------------
module tick_countdown #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (tick) begin
      if (load) begin
        count_reg <= load_value;
      end else if (count_reg != '0) begin
        count_reg <= count_reg - WIDTH'(1);
      end
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/player_state_controller.sv
// -----------------------------------------------------------------------------
// player_state_controller
// Game-state side of one player's movement interface. Consumes the movement /
// attack requests, owns position, facing, jump height and the attack / crouch /
// stun timing, and returns status bits to the movement handler. All state moves
// only on gameTicks; every output is registered.
//
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   gameTicks                       : one-clk game tick enable
//   movingLeft, movingRight         : walk requests
//   isJumping, isCrouching          : jump / crouch start requests
//   isBlocking                      : block held
//   comboMove[1:0]                  : 0 none, 1 normal, 2 special, 3 super
//   hitReceived                     : opponent hit, sampled with gameTicks
//   isCrouched, isInAir, isStunned,
//   isPerformingAttackAnimation     : status back to the handler
//   activeAttack[1:0]               : combo being animated, 0 when not attacking
//   attackStart, blockedHit         : one-clk event pulses
//   xPos[6:0], yOffset[5:0]         : position / height above ground
//   facingRight                     : last accepted horizontal direction
//
// Build option: PLAYER_AIR_CONTROL_EN -- when defined, walking is also applied
// during a jump; otherwise position and facing are frozen while airborne.
// -----------------------------------------------------------------------------
module player_state_controller
  import player_state_pkg::*;
#(
  parameter int X_MIN        = 0,
  parameter int X_MAX        = SCREEN_X_MAX,
  parameter int X_START      = 10,
  parameter int WALK_STEP    = 1,
  parameter int JUMP_HALF    = 8,
  parameter int CROUCH_TICKS = 8,
  parameter int ATK1_TICKS   = 4,
  parameter int ATK2_TICKS   = 8,
  parameter int ATK3_TICKS   = 12,
  parameter int STUN_TICKS   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       gameTicks,
  input  logic       movingLeft,
  input  logic       movingRight,
  input  logic       isJumping,
  input  logic       isCrouching,
  input  logic       isBlocking,
  input  logic [1:0] comboMove,
  input  logic       hitReceived,
  output logic       isCrouched,
  output logic       isInAir,
  output logic       isStunned,
  output logic       isPerformingAttackAnimation,
  output logic [1:0] activeAttack,
  output logic       attackStart,
  output logic       blockedHit,
  output logic [6:0] xPos,
  output logic [5:0] yOffset,
  output logic       facingRight
);

  player_state_t state_reg, state_next;
  logic [6:0] x_reg, x_next;
  logic [5:0] y_reg, y_next;
  logic       facing_reg, facing_next;
  logic [1:0] act_reg, act_next;
  logic       rising_reg, rising_next;
  logic       attack_start_reg, attack_start_next;
  logic       blocked_hit_reg, blocked_hit_next;
  logic       crouched_reg, in_air_reg, stunned_reg, attacking_reg;

  logic       airborne;
  logic       hit_blocked, take_hit;
  logic       start_attack, start_jump, start_crouch;
  logic       walk_state, do_walk;
  logic       timer_load, timer_zero, timer_expiring, timer_tick;
  logic [4:0] timer_load_value, timer_count;

  // ---------------------------------------------------------------------------
  // Per-tick decisions, in priority order: hit > combo > jump > crouch > walk.
  // ---------------------------------------------------------------------------
  assign airborne    = (y_reg != 6'd0);
  assign hit_blocked = hitReceived && isBlocking && !airborne &&
                       ((state_reg == ST_IDLE) || (state_reg == ST_CROUCH));
  assign take_hit    = hitReceived && !hit_blocked;

  assign start_attack = !hitReceived && (comboMove != COMBO_NONE) &&
                        ((state_reg == ST_IDLE) || (state_reg == ST_CROUCH));
  assign start_jump   = !hitReceived && (comboMove == COMBO_NONE) &&
                        (state_reg == ST_IDLE) && isJumping;
  assign start_crouch = !hitReceived && (comboMove == COMBO_NONE) &&
                        (state_reg == ST_IDLE) && !isJumping && isCrouching;

`ifdef PLAYER_AIR_CONTROL_EN
  assign walk_state = (state_reg == ST_IDLE) || (state_reg == ST_JUMP);
`else
  // A jump is always airborne, so this leaves walking to IDLE on the ground.
  assign walk_state = ((state_reg == ST_IDLE) || (state_reg == ST_JUMP)) && !airborne;
`endif

  assign do_walk = !hitReceived && walk_state && (movingLeft ^ movingRight) &&
                   !start_attack && !start_jump && !start_crouch;

  // ---------------------------------------------------------------------------
  // One shared timer: attack, crouch and stun never overlap. An absorbed hit
  // consumes the whole tick, so the timer is frozen on that tick as well.
  // ---------------------------------------------------------------------------
  assign timer_load = take_hit || start_attack || start_crouch;
  assign timer_tick = gameTicks && !hit_blocked;

  always_comb begin
    timer_load_value = 5'(STUN_TICKS);
    if (!take_hit && start_attack) begin
      unique case (comboMove)
        COMBO_NORMAL:  timer_load_value = 5'(ATK1_TICKS);
        COMBO_SPECIAL: timer_load_value = 5'(ATK2_TICKS);
        COMBO_SUPER:   timer_load_value = 5'(ATK3_TICKS);
        default:       timer_load_value = 5'd0;
      endcase
    end else if (!take_hit && start_crouch) begin
      timer_load_value = 5'(CROUCH_TICKS);
    end
  end

  tick_countdown #(
    .WIDTH(5)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .tick      (timer_tick),
    .load      (timer_load),
    .load_value(timer_load_value),
    .count     (timer_count),
    .zero      (timer_zero)
  );

  // True when this tick's decrement leaves the timer at zero.
  assign timer_expiring = timer_zero || (timer_count == 5'd1);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next        = state_reg;
    x_next            = x_reg;
    y_next            = y_reg;
    facing_next       = facing_reg;
    act_next          = act_reg;
    rising_next       = rising_reg;
    attack_start_next = 1'b0;
    blocked_hit_next  = 1'b0;

    if (gameTicks) begin
      if (hit_blocked) begin
        blocked_hit_next = 1'b1;
      end else if (take_hit) begin
        // Height is kept; the player falls back down while stunned.
        state_next = ST_STUN;
        act_next   = COMBO_NONE;
      end else if (start_attack) begin
        state_next        = ST_ATTACK;
        act_next          = comboMove;
        attack_start_next = 1'b1;
      end else begin
        if (do_walk) begin
          x_next      = walk_step_x(x_reg, movingRight, WALK_STEP, X_MIN, X_MAX);
          facing_next = movingRight;
        end
        unique case (state_reg)
          ST_IDLE: begin
            if (start_jump) begin
              state_next  = ST_JUMP;
              y_next      = 6'd1;
              rising_next = (JUMP_HALF > 1);
            end else if (start_crouch) begin
              state_next = ST_CROUCH;
            end
          end
          ST_CROUCH: begin
            if (timer_expiring) state_next = ST_IDLE;
          end
          ST_JUMP: begin
            if (rising_reg) begin
              y_next = y_reg + 6'd1;
              if ((y_reg + 6'd1) == 6'(JUMP_HALF)) rising_next = 1'b0;
            end else begin
              y_next = y_reg - 6'd1;
              if (y_reg == 6'd1) state_next = ST_IDLE;
            end
          end
          ST_ATTACK: begin
            if (timer_expiring) begin
              state_next = ST_IDLE;
              act_next   = COMBO_NONE;
            end
          end
          ST_STUN: begin
            if (airborne) y_next = y_reg - 6'd1;
            // Leave only once both the stun time and the fall are complete.
            if (timer_expiring && (y_reg <= 6'd1)) state_next = ST_IDLE;
          end
          default: state_next = ST_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs (status decoded from the next state so it is
  // aligned with position and height).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      x_reg            <= 7'(X_START);
      y_reg            <= 6'd0;
      facing_reg       <= 1'b1;
      act_reg          <= COMBO_NONE;
      rising_reg       <= 1'b0;
      attack_start_reg <= 1'b0;
      blocked_hit_reg  <= 1'b0;
      crouched_reg     <= 1'b0;
      in_air_reg       <= 1'b0;
      stunned_reg      <= 1'b0;
      attacking_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      x_reg            <= x_next;
      y_reg            <= y_next;
      facing_reg       <= facing_next;
      act_reg          <= act_next;
      rising_reg       <= rising_next;
      attack_start_reg <= attack_start_next;
      blocked_hit_reg  <= blocked_hit_next;
      crouched_reg     <= (state_next == ST_CROUCH);
      in_air_reg       <= (y_next != 6'd0);
      stunned_reg      <= (state_next == ST_STUN);
      attacking_reg    <= (state_next == ST_ATTACK);
    end
  end

  assign isCrouched                  = crouched_reg;
  assign isInAir                     = in_air_reg;
  assign isStunned                   = stunned_reg;
  assign isPerformingAttackAnimation = attacking_reg;
  assign activeAttack                = act_reg;
  assign attackStart                 = attack_start_reg;
  assign blockedHit                  = blocked_hit_reg;
  assign xPos                        = x_reg;
  assign yOffset                     = y_reg;
  assign facingRight                 = facing_reg;

endmodule
